// File: rtl/layer_sequencer.sv
// Launches one time step per event-control layer as a wavefront pipeline and
// counts completed steps until the last layer has run NUM_STEPS of them.
//
// state | meaning
// IDLE  | waiting for start; counters hold the result of the last inference
// RUN   | layers are being launched and their completions counted
module layer_sequencer #(
  parameter int NUM_LAYERS = 4,
  parameter int NUM_STEPS  = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_start,
  output logic [7:0]            time_step,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int         LAST  = NUM_LAYERS - 1;
  localparam logic [7:0] STEPS = 8'(NUM_STEPS);

  state_e                state_q, state_d;
  logic [7:0]            ls_q [NUM_LAYERS];
  logic [7:0]            ls_d [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] run_q, run_d;
  logic [NUM_LAYERS-1:0] layer_start_q, layer_start_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [NUM_LAYERS-1:0] base_ok, prev_ok, next_ok, elig;
  logic [NUM_LAYERS-1:0] done_ok, done_bad;
  logic                  launch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A layer may start when it has input from the layer below and the layer
  // above has already consumed the single buffered output of its last step.
  always_comb begin
    base_ok = '0;
    prev_ok = '1;
    next_ok = '1;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      base_ok[i] = (state_q == S_RUN) && !run_q[i] && (ls_q[i] < STEPS);
    end
    for (int i = 1; i < NUM_LAYERS; i++) begin
      prev_ok[i] = ls_q[i-1] > ls_q[i];
    end
    for (int i = 0; i < LAST; i++) begin
      next_ok[i] = ({1'b0, ls_q[i+1]} + {8'd0, run_q[i+1]}) == {1'b0, ls_q[i]};
    end
  end

  assign elig     = base_ok & prev_ok & next_ok;
  assign done_ok  = (state_q == S_RUN) ? (layer_done & run_q) : '0;
  assign done_bad = layer_done & ~done_ok;
  assign launch   = (state_q == S_IDLE) && start;

  // Layer 0 is the only layer eligible on freshly cleared counters, so it is
  // launched directly on the IDLE->RUN edge.
  always_comb begin
    run_d = run_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      ls_d[i] = ls_q[i];
    end
    if (launch) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        ls_d[i] = '0;
      end
      run_d = {{(NUM_LAYERS-1){1'b0}}, 1'b1};
    end else if (state_q == S_RUN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (done_ok[i]) begin
          ls_d[i] = ls_q[i] + 8'd1;
        end
      end
      run_d = (run_q & ~done_ok) | elig;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (ls_d[LAST] == STEPS) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    layer_start_d = '0;
    if (launch) begin
      layer_start_d[0] = 1'b1;
    end else if (state_q == S_RUN) begin
      layer_start_d = elig;
    end
    done_d = (state_q == S_RUN) && (state_d == S_IDLE);
    err_d  = err_q | (|done_bad);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        ls_q[i] <= '0;
      end
      run_q         <= '0;
      layer_start_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        ls_q[i] <= ls_d[i];
      end
      run_q         <= run_d;
      layer_start_q <= layer_start_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign layer_start = layer_start_q;
  assign time_step   = ls_q[LAST];
  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: two instances (2 layers x 3 steps, 4 layers x 1 step)
// checked every cycle against a count-based model plus hand-computed timings.
module tb_layer_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a;
  logic [1:0] auto_a, man_a, a_ld, a_lst;
  logic [7:0] a_ts;
  logic       a_busy, a_done, a_err;

  logic       rst_b, start_b;
  logic [3:0] auto_b, man_b, b_ld, b_lst;
  logic [7:0] b_ts;
  logic       b_busy, b_done, b_err;

  assign a_ld = auto_a | man_a;
  assign b_ld = auto_b | man_b;

  layer_sequencer #(.NUM_LAYERS(2), .NUM_STEPS(3)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .layer_done(a_ld),
    .layer_start(a_lst), .time_step(a_ts), .busy(a_busy), .done(a_done), .err(a_err)
  );

  layer_sequencer #(.NUM_LAYERS(4), .NUM_STEPS(1)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .layer_done(b_ld),
    .layer_start(b_lst), .time_step(b_ts), .busy(b_busy), .done(b_done), .err(b_err)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Model: per layer, how many steps were started and how many completed.
  int         m_ns [2][8];
  int         m_nd [2][8];
  logic [7:0] m_start [2];
  logic       m_busy [2];
  logic       m_donep [2];
  logic       m_err [2];

  task automatic model_step(input int k, input int nl, input int lim,
                            input logic r, input logic s, input logic [7:0] ld);
    logic [7:0] el;
    bit ok;
    if (r) begin
      for (int i = 0; i < 8; i++) begin m_ns[k][i] = 0; m_nd[k][i] = 0; end
      m_start[k] = '0; m_busy[k] = 1'b0; m_donep[k] = 1'b0; m_err[k] = 1'b0;
      return;
    end
    m_start[k] = '0;
    m_donep[k] = 1'b0;
    el = '0;
    if (m_busy[k]) begin
      for (int i = 0; i < nl; i++) begin
        ok = (m_ns[k][i] == m_nd[k][i]) && (m_nd[k][i] < lim);
        if (i > 0 && !(m_nd[k][i-1] > m_nd[k][i])) ok = 1'b0;
        if (i < nl - 1 && m_ns[k][i+1] != m_nd[k][i]) ok = 1'b0;
        el[i] = ok;
      end
    end
    for (int i = 0; i < nl; i++) begin
      if (ld[i]) begin
        if (m_busy[k] && m_ns[k][i] > m_nd[k][i]) m_nd[k][i]++;
        else m_err[k] = 1'b1;
      end
    end
    if (!m_busy[k]) begin
      if (s) begin
        m_busy[k] = 1'b1;
        for (int i = 0; i < 8; i++) begin m_ns[k][i] = 0; m_nd[k][i] = 0; end
        m_ns[k][0] = 1;
        m_start[k] = 8'h01;
      end
    end else begin
      for (int i = 0; i < nl; i++) begin
        if (el[i]) begin m_ns[k][i]++; m_start[k][i] = 1'b1; end
      end
      if (m_nd[k][nl-1] == lim) begin m_busy[k] = 1'b0; m_donep[k] = 1'b1; end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 2, 3, rst_a, start_a, {6'b0, a_ld});
    model_step(1, 4, 1, rst_b, start_b, {4'b0, b_ld});
  end

  always @(negedge clk) begin
    cmp("a_layer_start", a_lst, m_start[0]);
    cmp("a_time_step", a_ts, m_nd[0][1]);
    cmp("a_busy", a_busy, m_busy[0]);
    cmp("a_done", a_done, m_donep[0]);
    cmp("a_err", a_err, m_err[0]);
    cmp("b_layer_start", b_lst, m_start[1]);
    cmp("b_time_step", b_ts, m_nd[1][3]);
    cmp("b_busy", b_busy, m_busy[1]);
    cmp("b_done", b_done, m_donep[1]);
    cmp("b_err", b_err, m_err[1]);
  end

  // Responder: each layer returns layer_done a fixed latency after its start.
  int lat_a [2];
  int lat_b [4];
  int cnt_a [2];
  int cnt_b [4];

  always @(posedge clk) begin
    if (rst_a) for (int i = 0; i < 2; i++) cnt_a[i] = 0;
    if (rst_b) for (int i = 0; i < 4; i++) cnt_b[i] = 0;
    #2;
    auto_a = '0;
    auto_b = '0;
    for (int i = 0; i < 2; i++) begin
      if (cnt_a[i] > 0) begin cnt_a[i]--; if (cnt_a[i] == 0) auto_a[i] = 1'b1; end
      if (a_lst[i] === 1'b1) cnt_a[i] = lat_a[i];
    end
    for (int i = 0; i < 4; i++) begin
      if (cnt_b[i] > 0) begin cnt_b[i]--; if (cnt_b[i] == 0) auto_b[i] = 1'b1; end
      if (b_lst[i] === 1'b1) cnt_b[i] = lat_b[i];
    end
  end

  // Per-run observations, cleared when a start is accepted.
  int a_starts [2];
  int a_dc [2];
  int a_dones, a_done_cyc, a_seq, a_prev_ts, a_gap;
  int b_starts [4];
  int b_start_cyc [4];
  int b_dones, b_done_cyc;

  always @(negedge clk) begin
    if (start_a === 1'b1 && a_busy === 1'b0) begin
      for (int i = 0; i < 2; i++) begin a_starts[i] = 0; a_dc[i] = 0; end
      a_dones = 0; a_done_cyc = 0; a_seq = 0; a_gap = 0; a_prev_ts = int'(a_ts);
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (a_lst[i] === 1'b1) a_starts[i]++;
        if (a_ld[i] === 1'b1) a_dc[i]++;
      end
      if (a_done === 1'b1) begin a_dones++; a_done_cyc = cyc; end
      if (int'(a_ts) != a_prev_ts && a_ts != 8'd0) a_seq = a_seq * 16 + int'(a_ts);
      a_prev_ts = int'(a_ts);
      if (a_dc[0] - a_dc[1] > a_gap) a_gap = a_dc[0] - a_dc[1];
    end
    if (start_b === 1'b1 && b_busy === 1'b0) begin
      for (int i = 0; i < 4; i++) begin b_starts[i] = 0; b_start_cyc[i] = 0; end
      b_dones = 0; b_done_cyc = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (b_lst[i] === 1'b1) begin b_starts[i]++; b_start_cyc[i] = cyc; end
      end
      if (b_done === 1'b1) begin b_dones++; b_done_cyc = cyc; end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int t0;

  task automatic start_run_a();
    t0 = cyc;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
  endtask

  task automatic wait_a_done(input string nm, input int budget);
    int n;
    n = 0;
    while (a_done !== 1'b1 && n < budget) begin step(); n++; end
    cmp(nm, a_done, 1);
  endtask

  int exp_b_cyc [4];

  initial begin
    rst_a = 1'b1; start_a = 1'b0; man_a = '0;
    rst_b = 1'b1; start_b = 1'b0; man_b = '0;
    lat_a[0] = 4; lat_a[1] = 4;
    for (int i = 0; i < 4; i++) lat_b[i] = 3;
    exp_b_cyc[0] = 1; exp_b_cyc[1] = 6; exp_b_cyc[2] = 11; exp_b_cyc[3] = 16;
    step();
    step();
    cmp("rst_a_layer_start", a_lst, 0);
    cmp("rst_a_time_step", a_ts, 0);
    cmp("rst_a_busy_done_err", {a_busy, a_done, a_err}, 0);
    cmp("rst_b_outputs", {b_lst, b_ts, b_busy, b_done, b_err}, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    step();

    // 2 layers x 3 steps, 4-cycle latency on both
    start_run_a();
    cmp("a1_first_start", a_lst, 2'b01);
    wait_a_done("a1_done_seen", 200);
    step();
    cmp("a1_done_cycle", a_done_cyc - t0, 26);
    cmp("a1_starts_l0", a_starts[0], 3);
    cmp("a1_starts_l1", a_starts[1], 3);
    cmp("a1_done_pulses", a_dones, 1);
    cmp("a1_time_step_seq", a_seq, 32'h123);
    cmp("a1_busy_after", a_busy, 0);
    step();
    cmp("a1_time_step_held", a_ts, 3);

    // slow upper layer: lower layer must wait for its buffer to drain
    lat_a[0] = 2; lat_a[1] = 20;
    start_run_a();
    wait_a_done("a2_done_seen", 300);
    step();
    cmp("a2_done_cycle", a_done_cyc - t0, 70);
    cmp("a2_max_gap", a_gap, 2);
    cmp("a2_starts_l0", a_starts[0], 3);
    cmp("a2_starts_l1", a_starts[1], 3);

    // both layers finish in the same cycle twice
    lat_a[0] = 3; lat_a[1] = 4;
    start_run_a();
    wait_a_done("a5_done_seen", 200);
    step();
    cmp("a5_done_cycle", a_done_cyc - t0, 23);
    cmp("a5_starts_l1", a_starts[1], 3);

    // stray layer_done in IDLE
    man_a = 2'b10;
    step();
    man_a = 2'b00;
    cmp("a3_err_set", a_err, 1);
    cmp("a3_time_step_kept", a_ts, 3);
    step(); step(); step();
    cmp("a3_err_sticky", a_err, 1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    cmp("a3_err_cleared", a_err, 0);

    // start while running is ignored; reset mid-inference
    lat_a[0] = 4; lat_a[1] = 4;
    start_run_a();
    step(); step();
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    cmp("a4_no_extra_start", a_lst, 0);
    cmp("a4_still_busy", a_busy, 1);
    begin
      int n;
      n = 0;
      while (a_ts !== 8'd1 && n < 40) begin step(); n++; end
      cmp("a4_step1_cycle", cyc - t0, 12);
    end
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    cmp("a4_busy_after_rst", a_busy, 0);
    cmp("a4_no_done_after_rst", a_done, 0);
    man_a = 2'b01;
    step();
    man_a = 2'b00;
    cmp("a4_late_done_err", a_err, 1);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;

    // 4 layers x 1 step: one launch per layer, in order
    t0 = cyc;
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    cmp("b_first_start", b_lst, 4'b0001);
    begin
      int n;
      n = 0;
      while (b_done !== 1'b1 && n < 100) begin step(); n++; end
      cmp("b_done_seen", b_done, 1);
    end
    step();
    cmp("b_done_cycle", b_done_cyc - t0, 20);
    cmp("b_done_pulses", b_dones, 1);
    for (int i = 0; i < 4; i++) begin
      cmp("b_start_cycle", b_start_cyc[i] - t0, exp_b_cyc[i]);
      cmp("b_start_count", b_starts[i], 1);
    end
    cmp("b_time_step_final", b_ts, 1);

    // reset wins over start in the same cycle
    start_b = 1'b1; rst_b = 1'b1;
    step();
    start_b = 1'b0; rst_b = 1'b0;
    cmp("b_rst_over_start_busy", b_busy, 0);
    step();
    cmp("b_rst_over_start_lst", b_lst, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule
